// File: rtl/diag_pkg.sv
// Shared definitions for the diagnostic sequencer: code space and FSM state encoding.
package diag_pkg;

  localparam int unsigned DIAG_CODES = 8;
  localparam int unsigned CODE_W     = 3;

  typedef enum logic [2:0] {
    StIdle,
    StScan,
    StDrive,
    StSample,
    StEmit,
    StDone
  } state_e;

endpackage

// File: rtl/diag_bit_shifter.sv
// Operand/result datapath for diag_sequencer: latched operand words, bit index and
// result accumulator, stepped by the controlling FSM.
module diag_bit_shifter
  import diag_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic             sample_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             e_i,
  output logic             a_nxt_o,
  output logic             b_nxt_o,
  output logic             last_o,
  output logic [WIDTH-1:0] acc_o
);

  localparam int unsigned BitW = $clog2(WIDTH);
  localparam logic [BitW-1:0] BitLast = BitW'(WIDTH - 1);

  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [BitW-1:0]  bit_q, bit_d;

  always_comb begin
    op_a_d = op_a_q;
    op_b_d = op_b_q;
    acc_d  = acc_q;
    bit_d  = bit_q;
    if (load_i) begin
      op_a_d = op_a_i;
      op_b_d = op_b_i;
    end
    if (clr_i) begin
      bit_d = '0;
      acc_d = '0;
    end
    if (sample_i) begin
      acc_d[bit_q] = e_i;
    end
    if (inc_i) begin
      bit_d = bit_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_a_q <= '0;
      op_b_q <= '0;
      acc_q  <= '0;
      bit_q  <= '0;
    end else begin
      op_a_q <= op_a_d;
      op_b_q <= op_b_d;
      acc_q  <= acc_d;
      bit_q  <= bit_d;
    end
  end

  // Look-ahead operand bits so the FSM can register A/B for the bit about to be driven.
  assign a_nxt_o = op_a_q[bit_d];
  assign b_nxt_o = op_b_q[bit_d];
  assign last_o  = (bit_q == BitLast);
  assign acc_o   = acc_q;

endmodule

// File: rtl/diag_sequencer.sv
// Walks enabled select codes, serially drives operand bits, collects E into result words.
// Optional DIAG_SEQ_PARITY_EN adds res_parity (XOR of res_data).
module diag_sequencer
  import diag_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [7:0]       code_mask,
  output logic             s0,
  output logic             s1,
  output logic             s2,
  output logic             A,
  output logic             B,
  input  logic             E,
  output logic             busy,
  output logic             done,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [2:0]       res_code,
  output logic [WIDTH-1:0] res_data
`ifdef DIAG_SEQ_PARITY_EN
  ,
  output logic             res_parity
`endif
);

  localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CntW-1:0]   SettleLast = CntW'(SETTLE - 1);
  localparam logic [CODE_W-1:0] CodeLast   = CODE_W'(DIAG_CODES - 1);

  state_e            state_q, state_d;
  logic [CODE_W-1:0] ptr_q, ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [7:0]        mask_q, mask_d;

  logic [CODE_W-1:0] sel_q, sel_d;
  logic              a_q, a_d, b_q, b_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              valid_q, valid_d;
  logic [CODE_W-1:0] code_q, code_d;

  logic             sh_load, sh_clr, sh_inc, sh_sample;
  logic             a_nxt, b_nxt, bit_last, drv;
  logic [WIDTH-1:0] acc;

  diag_bit_shifter #(
    .WIDTH (WIDTH)
  ) u_shifter (
    .clk_i    (clk),
    .rst_i    (rst),
    .load_i   (sh_load),
    .clr_i    (sh_clr),
    .inc_i    (sh_inc),
    .sample_i (sh_sample),
    .op_a_i   (op_a),
    .op_b_i   (op_b),
    .e_i      (E),
    .a_nxt_o  (a_nxt),
    .b_nxt_o  (b_nxt),
    .last_o   (bit_last),
    .acc_o    (acc)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    mask_d    = mask_q;
    sh_load   = 1'b0;
    sh_clr    = 1'b0;
    sh_inc    = 1'b0;
    sh_sample = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          sh_load = 1'b1;
          mask_d  = code_mask;
          ptr_d   = '0;
          state_d = StScan;
        end
      end
      StScan: begin
        if (mask_q[ptr_q]) begin
          sh_clr  = 1'b1;
          cnt_d   = '0;
          state_d = StDrive;
        end else if (ptr_q == CodeLast) begin
          state_d = StDone;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      StDrive: begin
        if (cnt_q == SettleLast) begin
          state_d = StSample;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StSample: begin
        sh_sample = 1'b1;
        if (bit_last) begin
          state_d = StEmit;
        end else begin
          sh_inc  = 1'b1;
          cnt_d   = '0;
          state_d = StDrive;
        end
      end
      StEmit: begin
        if (res_ready) begin
          if (ptr_q == CodeLast) begin
            state_d = StDone;
          end else begin
            ptr_d   = ptr_q + 1'b1;
            state_d = StScan;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Outputs are registered, so they are derived from the next state.
    drv     = (state_d == StDrive) || (state_d == StSample);
    sel_d   = drv ? ptr_d : '0;
    a_d     = drv & a_nxt;
    b_d     = drv & b_nxt;
    valid_d = (state_d == StEmit);
    code_d  = valid_d ? ptr_d : '0;
    busy_d  = (state_d != StIdle) && (state_d != StDone);
    done_d  = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      sel_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      sel_q   <= sel_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      code_q  <= code_d;
    end
  end

  assign s0        = sel_q[0];
  assign s1        = sel_q[1];
  assign s2        = sel_q[2];
  assign A         = a_q;
  assign B         = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign res_valid = valid_q;
  assign res_code  = code_q;
  // Accumulator is frozen during EMIT; gating keeps res_data 0 outside it.
  assign res_data  = valid_q ? acc : '0;

`ifdef DIAG_SEQ_PARITY_EN
  assign res_parity = valid_q & (^acc);
`endif

endmodule

// File: tb/tb_diag_sequencer.sv
// Self-checking bench for diag_sequencer with E = s0 ? A&B : A|B, WIDTH=8, SETTLE=1.
module tb_diag_sequencer;

  localparam int W = 8;
  localparam int S = 1;

  logic       clk = 1'b0;
  logic       rst, start, res_ready;
  logic [7:0] op_a, op_b, code_mask;
  logic       s0, s1, s2, a_o, b_o, e;
  logic       busy, done, res_valid;
  logic [2:0] res_code;
  logic [7:0] res_data;
`ifdef DIAG_SEQ_PARITY_EN
  logic       res_parity;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0] got_code[$];
  logic [7:0] got_data[$];
  int         first_valid, done_cyc, busy_bad, stab_bad, par_bad;
  logic       first_par;

  always #5 clk = ~clk;

  assign e = s0 ? (a_o & b_o) : (a_o | b_o);

  diag_sequencer #(
    .WIDTH  (W),
    .SETTLE (S)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op_a      (op_a),
    .op_b      (op_b),
    .code_mask (code_mask),
    .s0        (s0),
    .s1        (s1),
    .s2        (s2),
    .A         (a_o),
    .B         (b_o),
    .E         (e),
    .busy      (busy),
    .done      (done),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_code  (res_code),
`ifdef DIAG_SEQ_PARITY_EN
    .res_parity(res_parity),
`endif
    .res_data  (res_data)
  );

  // Reference model: result word for a select code, and cycle counts with ready always high.
  function automatic logic [7:0] model_word(input int c, input logic [7:0] a, input logic [7:0] b);
    return (c % 2 == 1) ? (a & b) : (a | b);
  endfunction

  function automatic int model_first_valid(input logic [7:0] mask);
    int cur = 1;
    for (int c = 0; c < 8; c++) begin
      if (mask[c]) return cur + 1 + W * (S + 1);
      cur++;
    end
    return -1;
  endfunction

  function automatic int model_done(input logic [7:0] mask);
    int cur = 1;
    for (int c = 0; c < 8; c++) begin
      if (mask[c]) cur += 2 + W * (S + 1);
      else cur++;
    end
    return cur;
  endfunction

  // Runs one sequence; ready_mode 0: always 1, 1: random, 2: low for first `hold` EMIT cycles.
  task automatic collect(input logic [7:0] mask, input logic [7:0] a, input logic [7:0] b,
                         input int ready_mode, input int hold, input int restart_cyc);
    logic       pv = 1'b0, pr = 1'b0;
    logic [2:0] pc = '0;
    logic [7:0] pd = '0;
    int         vcnt = 0;
    got_code.delete();
    got_data.delete();
    first_valid = -1; done_cyc = -1; busy_bad = 0; stab_bad = 0; par_bad = 0; first_par = 1'b0;
    @(negedge clk);
    start = 1'b1; op_a = a; op_b = b; code_mask = mask; res_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= 600; cyc++) begin
      start = (cyc == restart_cyc);
      if (start) begin
        op_a = ~a; op_b = ~b; code_mask = ~mask;
      end
      case (ready_mode)
        0:       res_ready = 1'b1;
        1:       res_ready = 1'($urandom_range(0, 1));
        default: res_ready = (vcnt >= hold);
      endcase
      if (res_valid) begin
        if (first_valid < 0) begin
          first_valid = cyc;
`ifdef DIAG_SEQ_PARITY_EN
          first_par = res_parity;
`endif
        end
        vcnt++;
        if (res_ready) begin
          got_code.push_back(res_code);
          got_data.push_back(res_data);
        end
      end
      if (pv && !pr && (!res_valid || res_code !== pc || res_data !== pd)) stab_bad++;
      if (busy !== !done) busy_bad++;
`ifdef DIAG_SEQ_PARITY_EN
      if (res_parity !== (res_valid ? ^res_data : 1'b0)) par_bad++;
`endif
      pv = res_valid; pr = res_ready; pc = res_code; pd = res_data;
      if (done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; op_a = 8'hA5; op_b = 8'h5A; code_mask = 8'hFF; res_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({s2, s1, s0, a_o, b_o, busy, done, res_valid, res_code, res_data} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0",
               {s2, s1, s0, a_o, b_o, busy, done, res_valid, res_code, res_data});
    end
    start = 1'b0; rst = 1'b0; res_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle_busy: got %b required 0", busy);
    end
  endtask

  task automatic test_single();
    collect(8'h01, 8'h0F, 8'hF0, 0, 0, 0);
    n_checks++;
    if (first_valid != model_first_valid(8'h01)) begin
      n_fail++; $display("FAIL single_valid_cycle: got %0d required %0d", first_valid,
                         model_first_valid(8'h01));
    end
    n_checks++;
    if (got_code.size() != 1 || got_code[0] !== 3'd0 || got_data[0] !== 8'hFF) begin
      n_fail++; $display("FAIL single_result: got n=%0d code=%0h data=%0h required 1/0/ff",
                         got_code.size(), got_code.size() ? got_code[0] : 3'd0,
                         got_data.size() ? got_data[0] : 8'h0);
    end
    n_checks++;
    if (done_cyc != model_done(8'h01)) begin
      n_fail++; $display("FAIL single_done_cycle: got %0d required %0d", done_cyc,
                         model_done(8'h01));
    end
    n_checks++;
    if (busy_bad != 0) begin
      n_fail++; $display("FAIL single_busy: got %0d bad cycles required 0", busy_bad);
    end
  endtask

  task automatic test_two_codes();
    collect(8'h82, 8'h3C, 8'h0F, 1, 0, 0);
    n_checks++;
    if (got_code.size() != 2) begin
      n_fail++; $display("FAIL two_count: got %0d required 2", got_code.size());
    end else begin
      n_checks++;
      if (got_code[0] !== 3'd1 || got_data[0] !== 8'h0C || got_code[1] !== 3'd7 ||
          got_data[1] !== 8'h0C) begin
        n_fail++; $display("FAIL two_results: got %0h/%0h %0h/%0h required 1/0c 7/0c",
                           got_code[0], got_data[0], got_code[1], got_data[1]);
      end
    end
  endtask

  task automatic test_empty_mask();
    collect(8'h00, 8'hFF, 8'hFF, 0, 0, 0);
    n_checks++;
    if (done_cyc != 9 || first_valid != -1) begin
      n_fail++; $display("FAIL empty_mask: got done=%0d valid=%0d required 9/-1",
                         done_cyc, first_valid);
    end
    n_checks++;
    if (busy_bad != 0) begin
      n_fail++; $display("FAIL empty_busy: got %0d bad cycles required 0", busy_bad);
    end
  endtask

  task automatic test_backpressure();
    collect(8'h01, 8'h5A, 8'h33, 2, 5, 10);
    n_checks++;
    if (stab_bad != 0 || busy_bad != 0) begin
      n_fail++; $display("FAIL bp_stable: got stab=%0d busy=%0d required 0/0", stab_bad, busy_bad);
    end
    n_checks++;
    if (got_code.size() != 1 || got_data[0] !== model_word(0, 8'h5A, 8'h33)) begin
      n_fail++; $display("FAIL bp_result: got n=%0d required 1 word %0h", got_code.size(),
                         model_word(0, 8'h5A, 8'h33));
    end
    n_checks++;
    if (done_cyc != model_done(8'h01) + 5) begin
      n_fail++; $display("FAIL bp_done_cycle: got %0d required %0d", done_cyc,
                         model_done(8'h01) + 5);
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    start = 1'b1; op_a = 8'hFF; op_b = 8'hFF; code_mask = 8'h01; res_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({s2, s1, s0, a_o, b_o, busy, done, res_valid, res_code, res_data} !== 21'd0) begin
      n_fail++;
      $display("FAIL midrst_outputs: got %h required 0",
               {s2, s1, s0, a_o, b_o, busy, done, res_valid, res_code, res_data});
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || a_o !== 1'b0) begin
      n_fail++; $display("FAIL midrst_idle: got busy=%b A=%b required 0/0", busy, a_o);
    end
    collect(8'h01, 8'h12, 8'h40, 0, 0, 0);
    n_checks++;
    if (first_valid != model_first_valid(8'h01) || got_data.size() != 1 ||
        got_data[0] !== 8'h52) begin
      n_fail++; $display("FAIL midrst_rerun: got valid=%0d n=%0d required %0d/1 word 52",
                         first_valid, got_data.size(), model_first_valid(8'h01));
    end
  endtask

  task automatic test_random();
    logic [7:0] m, a, b;
    int         mode;
    logic [2:0] exp_code[$];
    logic [7:0] exp_data[$];
    for (int it = 0; it < 14; it++) begin
      m = 8'($urandom); a = 8'($urandom); b = 8'($urandom);
      mode = $urandom_range(0, 1);
      exp_code.delete(); exp_data.delete();
      for (int c = 0; c < 8; c++) begin
        if (m[c]) begin
          exp_code.push_back(3'(c));
          exp_data.push_back(model_word(c, a, b));
        end
      end
      collect(m, a, b, mode, 0, 0);
      n_checks++;
      if (got_code != exp_code || got_data != exp_data) begin
        n_fail++; $display("FAIL rand_results[%0d]: mask=%0h got n=%0d required n=%0d",
                           it, m, got_code.size(), exp_code.size());
      end
      n_checks++;
      if (stab_bad != 0 || busy_bad != 0 || par_bad != 0) begin
        n_fail++; $display("FAIL rand_status[%0d]: got stab=%0d busy=%0d par=%0d required 0",
                           it, stab_bad, busy_bad, par_bad);
      end
      if (mode == 0) begin
        n_checks++;
        if (done_cyc != model_done(m)) begin
          n_fail++; $display("FAIL rand_done[%0d]: got %0d required %0d", it, done_cyc,
                             model_done(m));
        end
      end
    end
  endtask

`ifdef DIAG_SEQ_PARITY_EN
  task automatic test_parity();
    collect(8'h02, 8'h01, 8'h01, 0, 0, 0);
    n_checks++;
    if (got_data.size() != 1 || got_data[0] !== 8'h01 || first_par !== 1'b1) begin
      n_fail++; $display("FAIL parity: got n=%0d par=%b required 1 word 01 par 1",
                         got_data.size(), first_par);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_two_codes();
    test_empty_mask();
    test_backpressure();
    test_mid_reset();
`ifdef DIAG_SEQ_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
